// File: rtl/agc_timing_pkg.sv
// Shared types and helpers for the AGC time-pulse generator.
// One-hot rings are limited to RING_MAX positions by the rotate helper.
package agc_timing_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTED   = 2'd1,
        ST_STEPPING = 2'd2
    } tp_state_e;

    localparam int unsigned NUM_TP_DEF     = 12;
    localparam int unsigned PHASES_DEF     = 4;
    localparam int unsigned SCALER_W_DEF   = 17;
    localparam int unsigned SCALER_DIV_DEF = 2;
    localparam int unsigned RING_MAX       = 32;

    // Rotate a one-hot ring of 'width' positions by one place, wrapping top to bit 0.
    function automatic logic [RING_MAX-1:0] onehot_rotate(input logic [RING_MAX-1:0] ring,
                                                          input int unsigned width);
        logic [RING_MAX-1:0] rot;
        logic [4:0]          msb;
        msb = 5'(width - 1);
        rot = ring << 1;
        if (ring[msb]) begin
            rot = {{(RING_MAX-1){1'b0}}, 1'b1};
        end
        return rot;
    endfunction

endpackage

// File: rtl/agc_scaler_chain.sv
// Free-running scaler: prescales CLK_EN ticks, then counts modulo 2^SCALER_W.
// F_STB flags every 0->1 transition of each stage, aligned with the FS update.
module agc_scaler_chain
    import agc_timing_pkg::*;
#(
    parameter int unsigned SCALER_W   = SCALER_W_DEF,
    parameter int unsigned SCALER_DIV = SCALER_DIV_DEF
) (
    input  logic                sim_clk_i,
    input  logic                reset_n_i,
    input  logic                clk_en_i,
    output logic [SCALER_W-1:0] fs_o,
    output logic [SCALER_W-1:0] f_stb_o
);

    // A divide-by-one still needs a one-bit prescaler that simply stays at zero.
    localparam int unsigned      PRE_W    = (SCALER_DIV > 1) ? $clog2(SCALER_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCALER_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [SCALER_W-1:0] fs_q, fs_d;
    logic [SCALER_W-1:0] f_stb_q;
    logic                pre_wrap;

    assign pre_wrap = clk_en_i && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        fs_d  = fs_q;
        if (clk_en_i) begin
            pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            if (pre_wrap) begin
                fs_d = fs_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sim_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pre_q   <= '0;
            fs_q    <= '0;
            f_stb_q <= '0;
        end else begin
            pre_q   <= pre_d;
            fs_q    <= fs_d;
            f_stb_q <= ~fs_q & fs_d;
        end
    end

    assign fs_o    = fs_q;
    assign f_stb_o = f_stb_q;

endmodule

// File: rtl/agc_timepulse_gen.sv
// Time-pulse generator: phase/TP one-hot rings, MCT strobe, STOP/STEP halt FSM,
// plus the free-running scaler chain which ignores the halt logic.
module agc_timepulse_gen
    import agc_timing_pkg::*;
#(
    parameter int unsigned NUM_TP     = NUM_TP_DEF,
    parameter int unsigned PHASES     = PHASES_DEF,
    parameter int unsigned SCALER_W   = SCALER_W_DEF,
    parameter int unsigned SCALER_DIV = SCALER_DIV_DEF
) (
    input  logic                sim_clk_i,
    input  logic                reset_n_i,
    input  logic                clk_en_i,
    input  logic                stop_i,
    input  logic                step_i,
    output logic [PHASES-1:0]   phs_o,
    output logic [NUM_TP-1:0]   tp_o,
    output logic                mct_stb_o,
    output logic                halted_o,
    output logic [SCALER_W-1:0] fs_o,
    output logic [SCALER_W-1:0] f_stb_o
);

    localparam logic [PHASES-1:0] PHS_FIRST = PHASES'(1);
    localparam logic [NUM_TP-1:0] TP_FIRST  = NUM_TP'(1);

    tp_state_e         state_q, state_d;
    logic [PHASES-1:0] phs_q, phs_d, phs_rot;
    logic [NUM_TP-1:0] tp_q, tp_d, tp_rot;
    logic              mct_q, mct_d;
    logic              arm_q, arm_d;
    logic              step_q;
    logic              halted_q;
    logic              step_rise, started, last_phase, mct_end;

    assign step_rise  = step_i & ~step_q;
    assign started    = |phs_q;
    assign last_phase = phs_q[PHASES-1];
    assign mct_end    = last_phase & tp_q[NUM_TP-1];
    assign phs_rot    = PHASES'(onehot_rotate(RING_MAX'(phs_q), PHASES));
    assign tp_rot     = NUM_TP'(onehot_rotate(RING_MAX'(tp_q), NUM_TP));

    always_comb begin
        state_d = state_q;
        phs_d   = phs_q;
        tp_d    = tp_q;
        mct_d   = 1'b0;
        arm_d   = arm_q;
        case (state_q)
            ST_RUN, ST_STEPPING: begin
                // Steps are only armed while halted; edges here are dropped, not queued.
                arm_d = 1'b0;
                if (clk_en_i) begin
                    if (!started) begin
                        phs_d = PHS_FIRST;
                        tp_d  = TP_FIRST;
                    end else if (mct_end) begin
                        mct_d = 1'b1;
                        if (stop_i) begin
                            state_d = ST_HALTED;
                            phs_d   = '0;
                            tp_d    = '0;
                        end else begin
                            state_d = ST_RUN;
                            phs_d   = PHS_FIRST;
                            tp_d    = TP_FIRST;
                        end
                    end else begin
                        phs_d = phs_rot;
                        if (last_phase) begin
                            tp_d = tp_rot;
                        end
                    end
                end
            end
            ST_HALTED: begin
                if (clk_en_i && !stop_i) begin
                    state_d = ST_RUN;
                    arm_d   = 1'b0;
                    phs_d   = PHS_FIRST;
                    tp_d    = TP_FIRST;
                end else if (clk_en_i && arm_q) begin
                    state_d = ST_STEPPING;
                    arm_d   = 1'b0;
                    phs_d   = PHS_FIRST;
                    tp_d    = TP_FIRST;
                end else begin
                    arm_d = arm_q | step_rise;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge sim_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_RUN;
            phs_q    <= '0;
            tp_q     <= '0;
            mct_q    <= 1'b0;
            arm_q    <= 1'b0;
            step_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phs_q    <= phs_d;
            tp_q     <= tp_d;
            mct_q    <= mct_d;
            arm_q    <= arm_d;
            step_q   <= step_i;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    agc_scaler_chain #(
        .SCALER_W  (SCALER_W),
        .SCALER_DIV(SCALER_DIV)
    ) u_scaler (
        .sim_clk_i(sim_clk_i),
        .reset_n_i(reset_n_i),
        .clk_en_i (clk_en_i),
        .fs_o     (fs_o),
        .f_stb_o  (f_stb_o)
    );

    assign phs_o     = phs_q;
    assign tp_o      = tp_q;
    assign mct_stb_o = mct_q;
    assign halted_o  = halted_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Scoreboard bench: two generator configurations share stimulus; a position-counter
// model predicts each cycle's outputs and a monitor compares them after every edge.
module tb_agc_timepulse_gen;

    localparam int NTP0 = 12, NPH0 = 4, SW0 = 17, SD0 = 2;
    localparam int NTP1 = 3,  NPH1 = 2, SW1 = 4,  SD1 = 2;
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, stop = 1'b0, step = 1'b0;
    always #5 clk = ~clk;

    logic [NPH0-1:0] phs0;  logic [NTP0-1:0] tp0;  logic [SW0-1:0] fs0, fstb0;  logic mct0, hlt0;
    logic [NPH1-1:0] phs1;  logic [NTP1-1:0] tp1;  logic [SW1-1:0] fs1, fstb1;  logic mct1, hlt1;

    agc_timepulse_gen u_dut0 (
        .sim_clk_i(clk), .reset_n_i(rst_n), .clk_en_i(ce), .stop_i(stop), .step_i(step),
        .phs_o(phs0), .tp_o(tp0), .mct_stb_o(mct0), .halted_o(hlt0), .fs_o(fs0), .f_stb_o(fstb0));

    agc_timepulse_gen #(.NUM_TP(NTP1), .PHASES(NPH1), .SCALER_W(SW1), .SCALER_DIV(SD1)) u_dut1 (
        .sim_clk_i(clk), .reset_n_i(rst_n), .clk_en_i(ce), .stop_i(stop), .step_i(step),
        .phs_o(phs1), .tp_o(tp1), .mct_stb_o(mct1), .halted_o(hlt1), .fs_o(fs1), .f_stb_o(fstb1));

    typedef struct {
        logic [31:0] phs, tp, mct, halted, fs, fstb;
    } exp_t;

    exp_t q0[$], q1[$];
    int   n_tests = 0, n_fail = 0;

    // Model: pos counts phase ticks 1..NTP*NPH inside the MCT, 0 means rings idle.
    int pos[2], mode[2], tickcnt[2];
    bit armed[2], step_prev[2];
    bit stop_lvl = 1'b0, step_lvl = 1'b0;

    function automatic logic [31:0] fs_of(int d, int cnt);
        int w, dv;
        w  = (d == 0) ? SW0 : SW1;
        dv = (d == 0) ? SD0 : SD1;
        return 32'((cnt / dv) % (1 << w));
    endfunction

    function automatic exp_t model_step(int d, bit r, bit c, bit s, bit st);
        exp_t e;
        int np, nt;
        bit rise;
        logic [31:0] old_fs;
        np = (d == 0) ? NPH0 : NPH1;
        nt = (d == 0) ? NTP0 : NTP1;
        e  = '{default: '0};
        if (!r) begin
            pos[d] = 0; mode[d] = M_RUN; armed[d] = 0; step_prev[d] = 0; tickcnt[d] = 0;
            return e;
        end
        rise = st && !step_prev[d];
        step_prev[d] = st;
        if (c) begin
            if (mode[d] == M_HALT) begin
                if (!s) begin
                    mode[d] = M_RUN; pos[d] = 1; armed[d] = 0;
                end else if (armed[d]) begin
                    mode[d] = M_STEP; pos[d] = 1; armed[d] = 0;
                end else begin
                    armed[d] = armed[d] | rise;
                end
            end else begin
                armed[d] = 0;
                if (pos[d] == 0) begin
                    pos[d] = 1;
                end else if (pos[d] == nt * np) begin
                    e.mct = 1;
                    if (s) begin mode[d] = M_HALT; pos[d] = 0; end
                    else begin mode[d] = M_RUN; pos[d] = 1; end
                end else begin
                    pos[d] = pos[d] + 1;
                end
            end
            old_fs = fs_of(d, tickcnt[d]);
            tickcnt[d] = tickcnt[d] + 1;
            e.fstb = ~old_fs & fs_of(d, tickcnt[d]);
        end else if (mode[d] == M_HALT) begin
            armed[d] = armed[d] | rise;
        end else begin
            armed[d] = 0;
        end
        e.fs     = fs_of(d, tickcnt[d]);
        e.halted = (mode[d] == M_HALT) ? 32'd1 : 32'd0;
        e.phs    = (pos[d] == 0) ? 32'd0 : (32'd1 << ((pos[d] - 1) % np));
        e.tp     = (pos[d] == 0) ? 32'd0 : (32'd1 << ((pos[d] - 1) / np));
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
        end
    endtask

    task automatic cmp0(exp_t e);
        chk("d0.phs", 32'(phs0), e.phs);   chk("d0.tp", 32'(tp0), e.tp);
        chk("d0.mct", 32'(mct0), e.mct);   chk("d0.halted", 32'(hlt0), e.halted);
        chk("d0.fs", 32'(fs0), e.fs);      chk("d0.fstb", 32'(fstb0), e.fstb);
    endtask

    task automatic cmp1(exp_t e);
        chk("d1.phs", 32'(phs1), e.phs);   chk("d1.tp", 32'(tp1), e.tp);
        chk("d1.mct", 32'(mct1), e.mct);   chk("d1.halted", 32'(hlt1), e.halted);
        chk("d1.fs", 32'(fs1), e.fs);      chk("d1.fstb", 32'(fstb1), e.fstb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin e = q0.pop_front(); cmp0(e); end
            if (q1.size() > 0) begin e = q1.pop_front(); cmp1(e); end
        end
    end

    task automatic cyc(bit r, bit c);
        @(negedge clk);
        rst_n = r; ce = c; stop = stop_lvl; step = step_lvl;
        q0.push_back(model_step(0, r, c, stop_lvl, step_lvl));
        q1.push_back(model_step(1, r, c, stop_lvl, step_lvl));
    endtask

    task automatic run_ticks(int n);
        for (int i = 0; i < 4 * n; i++) cyc(1'b1, (i % 4) == 3);
    endtask

    task automatic async_reset_check();
        exp_t z;
        z = '{default: '0};
        @(negedge clk);
        #2;
        rst_n = 1'b0; ce = 1'b0;
        #1;
        cmp0(z);
        cmp1(z);
        q0.push_back(model_step(0, 1'b0, 1'b0, stop_lvl, step_lvl));
        q1.push_back(model_step(1, 1'b0, 1'b0, stop_lvl, step_lvl));
    endtask

    initial begin : driver
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i & 1));
        // Three full MCTs free-running.
        run_ticks(148);
        // A STOP pulse that drops before the boundary must not halt.
        stop_lvl = 1'b1; run_ticks(10);
        stop_lvl = 1'b0; run_ticks(10);
        // Held STOP halts at the next boundary; scaler keeps counting while halted.
        stop_lvl = 1'b1; run_ticks(60);
        // Single step with STEP held high for several cycles.
        step_lvl = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        step_lvl = 1'b0;
        run_ticks(25);
        // Second STEP mid-MCT must not extend the run.
        step_lvl = 1'b1; run_ticks(1);
        step_lvl = 1'b0; run_ticks(40);
        // Release STOP: resume running from T01 PHS1.
        stop_lvl = 1'b0; run_ticks(10);
        // Random interplay of ticks, STOP and STEP.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) stop_lvl = ~stop_lvl;
            if ($urandom_range(0, 19) == 0)  step_lvl = ~step_lvl;
            cyc(1'b1, $urandom_range(0, 2) == 0);
        end
        // Mid-MCT asynchronous reset at T07 PHS2 of the default configuration.
        stop_lvl = 1'b0; step_lvl = 1'b0;
        cyc(1'b0, 1'b0);
        run_ticks(26);
        async_reset_check();
        cyc(1'b0, 1'b0);
        run_ticks(60);
        repeat (3) @(posedge clk);
        #2;
        chk("queue.drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
